rot_arb: RTL and testbench



---
 rtl/rot_arb_pkg.sv | 23 ++
 rtl/rot_arb_rotl.sv | 20 ++
 rtl/rot_arb.sv | 124 ++++++++++++
 tb/tb_rot_arb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_arb_pkg.sv
// Shared types and helpers for the round-robin rotate arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rot_arb_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    // Operation captured into the first pipeline stage.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              dir;   // 1 = rotate right
    } rot_op_t;

    // A right rotate by a equals a left rotate by (16 - a) mod 16, which is
    // just the two's-complement negation of a in 4 bits.
    function automatic logic [AMT_W-1:0] eff_amt(input logic [AMT_W-1:0] amt,
                                                 input logic             dir);
        return dir ? (AMT_W'(0) - amt) : amt;
    endfunction

endpackage

// File: rtl/rot_arb_rotl.sv
// Combinational 16-bit rotate-left by a 4-bit amount.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
// Ports: data_i operand, amt_i rotate amount, data_o rotated result.
module rot_arb_rotl
    import rot_arb_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amt_i,
    output logic [DATA_W-1:0] data_o
);

    // Shifting the doubled word left leaves the rotated value in the upper
    // half; amt 0 passes the operand through unchanged.
    logic [2*DATA_W-1:0] dbl;

    assign dbl    = {data_i, data_i} << amt_i;
    assign data_o = dbl[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/rot_arb.sv
// Round-robin arbiter sharing one rotate-left datapath among NREQ requesters.
// Latency: grant at edge N -> rsp_valid after edge N+1; 1 result/cycle.
// Backpressure: rsp_ready low holds S2, S1 fills once, then all req_ready drop.
// Ports: req_valid/req_ready/req_data/req_amt per-requester handshake,
//        rsp_valid/rsp_ready/rsp_data/rsp_id single tagged response port.
// Optional: ROT_ARB_ROTR_EN adds req_dir (1 = rotate right) per requester.
module rot_arb
    import rot_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    input  logic [NREQ*AMT_W-1:0]   req_amt,
`ifdef ROT_ARB_ROTR_EN
    input  logic [NREQ-1:0]         req_dir,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [IDW-1:0]          rsp_id
);

    logic [IDW-1:0]    ptr_q, ptr_d;
    rot_op_t           s1_q, s1_d;
    logic [IDW-1:0]    id1_q;
    logic              v1_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [IDW-1:0]    rsp_id_q;
    logic              rsp_valid_q;

    logic              s2_loads;
    logic              s1_free;
    logic              found;
    logic              grant;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    cand;
    logic [DATA_W-1:0] rot_out;

    assign s2_loads = v1_q & (~rsp_valid_q | rsp_ready);
    assign s1_free  = ~v1_q | s2_loads;

    // First valid requester scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held.
    assign grant = found & s1_free & rst_n;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.data = req_data[int'(win)*DATA_W +: DATA_W];
        s1_d.amt  = req_amt[int'(win)*AMT_W +: AMT_W];
`ifdef ROT_ARB_ROTR_EN
        s1_d.dir  = req_dir[win];
`else
        s1_d.dir  = 1'b0;
`endif
    end

    rot_arb_rotl u_rotl (
        .data_i (s1_q.data),
        .amt_i  (eff_amt(s1_q.amt, s1_q.dir)),
        .data_o (rot_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_q        <= '0;
            id1_q       <= '0;
            v1_q        <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                s1_q  <= s1_d;
                id1_q <= win;
            end
            // S1 stays occupied if refilled in the same cycle it drains.
            v1_q <= grant | (v1_q & ~s2_loads);
            if (s2_loads) begin
                rsp_data_q <= rot_out;
                rsp_id_q   <= id1_q;
            end
            rsp_valid_q <= s2_loads | (rsp_valid_q & ~rsp_ready);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_rot_arb.sv
// Directed bench for rot_arb with a scoreboard and a cycle model of the
// arbiter pointer and pipeline occupancy.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_rot_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic [15:0] req_amt;
    logic [3:0]  req_dir;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] d;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   acc_cnt = 0;
    int   res_cnt = 0;

    // Model state
    int   ptr_m = 0;
    logic v1m   = 1'b0;
    logic s2m   = 1'b0;

    always #5 clk = ~clk;

    rot_arb #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
`ifdef ROT_ARB_ROTR_EN
        .req_dir   (req_dir),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    // Bit-by-bit rotation: bit j of the operand lands at bit (j+a) mod 16.
    function automatic logic [15:0] m_rot(input logic [15:0] d, input int a, input logic dir);
        logic [15:0] r;
        int          la;
        la = dir ? ((16 - a) % 16) : a;
        r  = '0;
        for (int j = 0; j < 16; j++) r[(j + la) % 16] = d[j];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: model the arbiter, log handshakes, score responses.
    always @(negedge clk) begin
        logic       s2l, free, fnd;
        int         w;
        logic [3:0] exp_rdy;
        exp_t       e;
        if (!rst_n) begin
            ptr_m = 0;
            v1m   = 1'b0;
            s2m   = 1'b0;
            sb.delete();
        end else begin
            checks++;
            assert (rsp_valid === s2m) else begin
                errors++;
                $error("FAIL mon_rsp_valid observed=%0b expected=%0b", rsp_valid, s2m);
            end
            s2l  = v1m & (~s2m | rsp_ready);
            free = ~v1m | s2l;
            fnd  = 1'b0;
            w    = 0;
            for (int k = 0; k < 4; k++) begin
                if (!fnd && req_valid[(ptr_m + k) % 4]) begin
                    fnd = 1'b1;
                    w   = (ptr_m + k) % 4;
                end
            end
            exp_rdy = '0;
            if (free && fnd) exp_rdy[w] = 1'b1;
            checks++;
            assert (req_ready === exp_rdy) else begin
                errors++;
                $error("FAIL mon_req_ready observed=%b expected=%b", req_ready, exp_rdy);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.d  = m_rot(req_data[i*16 +: 16], int'(req_amt[i*4 +: 4]), req_dir[i]);
                    e.id = i;
                    sb.push_back(e);
                    grant_log.push_back(i);
                    acc_cnt++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                res_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow observed=result expected=none");
                end else begin
                    e = sb.pop_front();
                    checks++;
                    assert (rsp_data === e.d) else begin
                        errors++;
                        $error("FAIL sb_data observed=%h expected=%h", rsp_data, e.d);
                    end
                    checks++;
                    assert (int'(rsp_id) === e.id) else begin
                        errors++;
                        $error("FAIL sb_id observed=%0d expected=%0d", rsp_id, e.id);
                    end
                end
            end
            if (free && fnd) ptr_m = (w + 1) % 4;
            s2m = s2l ? 1'b1 : (rsp_ready ? 1'b0 : s2m);
            v1m = (free && fnd) ? 1'b1 : (s2l ? 1'b0 : v1m);
        end
    end

    task automatic send(input int i, input logic [15:0] d, input logic [3:0] a);
        logic ok;
        req_valid[i]        = 1'b1;
        req_data[i*16 +: 16] = d;
        req_amt[i*4 +: 4]    = a;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        chk("send_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_expect(input int i, input logic [15:0] d, input logic [3:0] a,
                               input logic [15:0] exp);
        logic ok;
        send(i, d, a);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sx_rsp_seen", {31'd0, ok}, 32'd1);
        chk("sx_data", {16'd0, rsp_data}, {16'd0, exp});
        chk("sx_id", {30'd0, rsp_id}, i);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic all_valid();
        for (int i = 0; i < 4; i++) begin
            req_data[i*16 +: 16] = 16'h1111 * 16'(i + 1);
            req_amt[i*4 +: 4]    = 4'(i + 1);
        end
        req_valid = 4'hF;
    endtask

    initial begin
        logic [15:0] hold;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        rsp_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request: ready same cycle, result two edges after.
        @(posedge clk);
        #1;
        req_valid[0]   = 1'b1;
        req_data[15:0] = 16'h8001;
        req_amt[3:0]   = 4'd1;
        @(negedge clk);
        chk("t1_ready", {28'd0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_not_yet", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_data", {16'd0, rsp_data}, 32'h0003);
        chk("t1_id", {30'd0, rsp_id}, 32'd0);
        @(posedge clk);
        #1;

        // Amount sweep
        send_expect(0, 16'h1234, 4'd0,  16'h1234);
        send_expect(1, 16'h1234, 4'd4,  16'h2341);
        send_expect(2, 16'h1234, 4'd15, 16'h091A);
        drain();

        // All requesters valid: strict rotation from requester 0.
        do_reset();
        grant_log.delete();
        @(posedge clk);
        #1;
        all_valid();
        repeat (12) @(posedge clk);
        #1;
        req_valid = '0;
        chk("rr_grant_count", grant_log.size(), 32'd12);
        for (int j = 0; j < 8 && j < grant_log.size(); j++) begin
            chk("rr_order", grant_log[j], j % 4);
        end
        drain();

        // Backpressure: only two accepted, output held stable.
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        res_cnt   = 0;
        all_valid();
        repeat (5) @(negedge clk);
        chk("bp_accepted", acc_cnt, 32'd2);
        chk("bp_ready_low", {28'd0, req_ready}, 32'd0);
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        hold = rsp_data;
        repeat (2) @(negedge clk);
        chk("bp_data_stable", {16'd0, rsp_data}, {16'd0, hold});
        chk("bp_ready_still_low", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        drain();
        chk("bp_results", res_cnt, 32'd2);

        // Async reset with S1 and S2 full
        rsp_ready = 1'b0;
        all_valid();
        repeat (3) @(negedge clk);
        chk("ar_full", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("ar_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("ar_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("ar_req_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", {28'd0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

`ifdef ROT_ARB_ROTR_EN
        // Right rotate
        req_dir[0] = 1'b1;
        send_expect(0, 16'h0003, 4'd1, 16'h8001);
        req_dir[0] = 1'b0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
